// File: rtl/risc_controller.sv
// VeriRisc 8-phase instruction sequencer and control-strobe decoder.
// Optional retired-instruction counter enabled by `CTRL_INSTR_CNT_EN.
module risc_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enab,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e
`ifdef CTRL_INSTR_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    INST_ADDR,
    INST_FETCH,
    INST_LOAD,
    IDLE,
    OP_ADDR,
    OP_FETCH,
    ALU_OP,
    STORE
  } phase_e;

  typedef enum logic [2:0] {
    OP_HLT,
    OP_SKZ,
    OP_ADD,
    OP_AND,
    OP_XOR,
    OP_LDA,
    OP_STO,
    OP_JMP
  } op_e;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;

  logic is_hlt, is_skz, is_sto, is_jmp;
  logic aluop;

  always_comb begin
    is_hlt = 1'b0;
    is_skz = 1'b0;
    is_sto = 1'b0;
    is_jmp = 1'b0;
    aluop  = 1'b0;
    unique case (1'b1)
      (opcode == OP_HLT): is_hlt = 1'b1;
      (opcode == OP_SKZ): is_skz = 1'b1;
      (opcode == OP_STO): is_sto = 1'b1;
      (opcode == OP_JMP): is_jmp = 1'b1;
      default:            aluop  = 1'b1;
    endcase
  end

  // Halting freezes the phase at OP_ADDR instead of advancing.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q && enab) begin
      if (phase_q == OP_ADDR && is_hlt) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_e'(phase_q + 3'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    unique case (phase_q)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        halt   = is_hlt;
        inc_pc = !is_hlt;
      end
      OP_FETCH: begin
        rd = aluop;
      end
      ALU_OP: begin
        rd     = aluop;
        inc_pc = is_skz && zero;
        ld_pc  = is_jmp;
      end
      STORE: begin
        rd     = aluop;
        ld_ac  = aluop;
        ld_pc  = is_jmp;
        wr     = is_sto;
        data_e = is_sto;
      end
    endcase
    // Stalls mask state-changing strobes; bus-facing ones stay put.
    if (halted_q) begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      halt   = 1'b1;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
    end else if (!enab) begin
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
    end
  end

`ifdef CTRL_INSTR_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (enab && !halted_q && phase_q == STORE && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_risc_controller.sv
// Scoreboard bench for risc_controller: directed per-phase strobe tables.
// Counter checks active when `CTRL_INSTR_CNT_EN is defined (CNT_WIDTH=2).
module tb_risc_controller;

  localparam int CW = 2;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  // {sel,rd,ld_ir,halt,inc_pc,ld_pc,ld_ac,wr,data_e}
  localparam logic [8:0] T_ALU [8] = '{
    9'h100, 9'h180, 9'h1C0, 9'h1C0,
    9'h010, 9'h080, 9'h080, 9'h084};
  localparam logic [8:0] T_SKZ1 [8] = '{
    9'h100, 9'h180, 9'h1C0, 9'h1C0,
    9'h010, 9'h000, 9'h010, 9'h000};
  localparam logic [8:0] T_SKZ0 [8] = '{
    9'h100, 9'h180, 9'h1C0, 9'h1C0,
    9'h010, 9'h000, 9'h000, 9'h000};
  localparam logic [8:0] T_STO [8] = '{
    9'h100, 9'h180, 9'h1C0, 9'h1C0,
    9'h010, 9'h000, 9'h000, 9'h003};
  localparam logic [8:0] T_JMP [8] = '{
    9'h100, 9'h180, 9'h1C0, 9'h1C0,
    9'h010, 9'h000, 9'h008, 9'h008};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enab = 1'b0;
  logic       zero = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic sel, rd, ld_ir, halt, inc_pc;
  logic ld_pc, ld_ac, wr, data_e;
`ifdef CTRL_INSTR_CNT_EN
  logic [CW-1:0] instr_cnt;
`endif

  always #5 clk = ~clk;

  risc_controller #(
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enab(enab),
    .opcode(opcode),
    .zero(zero),
    .sel(sel),
    .rd(rd),
    .ld_ir(ld_ir),
    .halt(halt),
    .inc_pc(inc_pc),
    .ld_pc(ld_pc),
    .ld_ac(ld_ac),
    .wr(wr),
    .data_e(data_e)
`ifdef CTRL_INSTR_CNT_EN
    ,
    .instr_cnt(instr_cnt)
`endif
  );

  typedef struct packed {
    logic [8:0]    vec;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;
  int   step_no = 0;

  logic [8:0] act;
  assign act = {sel, rd, ld_ir, halt, inc_pc,
                ld_pc, ld_ac, wr, data_e};

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (act !== e.vec) begin
          errors++;
          $display("FAIL strobes @%0t: got %b want %b",
                   $time, act, e.vec);
        end
`ifdef CTRL_INSTR_CNT_EN
        checks++;
        if (instr_cnt !== e.cnt) begin
          errors++;
          $display("FAIL instr_cnt @%0t: got %0d want %0d",
                   $time, instr_cnt, e.cnt);
        end
`endif
      end
    end
  end

  task automatic step(input logic r, input logic e,
                      input logic [2:0] op, input logic z,
                      input logic [8:0] v);
    exp_t x;
    @(posedge clk);
    #1;
    rst    = r;
    enab   = e;
    opcode = op;
    zero   = z;
    x.vec  = v;
    x.cnt  = CW'(exp_cnt);
    q.push_back(x);
    step_no++;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z,
                           input logic [8:0] t [8]);
    for (int p = 0; p < 8; p++) begin
      step(1'b1, 1'b1, op, z, t[p]);
    end
    if (exp_cnt < 3) exp_cnt++;
  endtask

  initial begin : stim
    int waited;
    step(1'b0, 1'b1, ADD, 1'b0, 9'h100);
    step(1'b0, 1'b1, ADD, 1'b0, 9'h100);
    for (int i = 0; i < 5; i++) run_instr(ADD, 1'b0, T_ALU);
    run_instr(SKZ, 1'b1, T_SKZ1);
    run_instr(SKZ, 1'b0, T_SKZ0);
    run_instr(STO, 1'b0, T_STO);
    run_instr(JMP, 1'b0, T_JMP);
    run_instr(XOR, 1'b1, T_ALU);
    run_instr(LDA, 1'b0, T_ALU);
    // stall across INST_LOAD
    step(1'b1, 1'b1, ADD, 1'b0, 9'h100);
    step(1'b1, 1'b1, ADD, 1'b0, 9'h180);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, ADD, 1'b0, 9'h180);
    step(1'b1, 1'b1, ADD, 1'b0, 9'h1C0);
    step(1'b1, 1'b1, ADD, 1'b0, 9'h1C0);
    step(1'b1, 1'b1, ADD, 1'b0, 9'h010);
    step(1'b1, 1'b1, ADD, 1'b0, 9'h080);
    step(1'b1, 1'b1, ADD, 1'b0, 9'h080);
    step(1'b1, 1'b1, ADD, 1'b0, 9'h084);
    // halt: stalled first, then latched
    for (int p = 0; p < 4; p++) step(1'b1, 1'b1, HLT, 1'b0, T_ALU[p]);
    step(1'b1, 1'b0, HLT, 1'b0, 9'h020);
    step(1'b1, 1'b0, HLT, 1'b0, 9'h020);
    step(1'b1, 1'b1, HLT, 1'b0, 9'h020);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'(i % 2), JMP, 1'b1, 9'h020);
    end
    exp_cnt = 0;
    step(1'b0, 1'b1, ADD, 1'b0, 9'h100);
    run_instr(ADD, 1'b0, T_ALU);
    step(1'b1, 1'b1, ADD, 1'b0, 9'h100);
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
